// File: rtl/scarv_rom_streamer.sv
// Streams a contiguous run of ROM words out through a valid/ready port via a 2-entry FIFO.
// Define SCARV_ROM_STREAMER_CHECKSUM_EN to enable the running-XOR checksum output.
module scarv_rom_streamer #(
    parameter  int unsigned DEPTH = 1024,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic             rom_cen,
    output logic [AW-1:0]    rom_addr,
    input  logic [WIDTH-1:0] rom_rdata,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [WIDTH-1:0] s_data,
    output logic             s_last,
    output logic [WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      issued_q, issued_d;
    logic             pend_q, pend_d;
    logic             pend_last_q, pend_last_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_last_q, head_last_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             tail_last_q, tail_last_d;

    logic       start_acc;
    logic       pop;
    logic       push;
    logic [2:0] occ;
    logic       room;
    logic       can_issue;
    logic       issue;

    always_comb begin
        start_acc = (state_q == StIdle) && start;
        pop       = (fifo_cnt_q != 2'd0) && s_ready;
        push      = pend_q;
        // Count a read as occupying a slot from issue until it is consumed.
        occ       = {1'b0, fifo_cnt_q} + {2'b00, pend_q};
        room      = occ < (3'd2 + {2'b00, pop});
        can_issue = issued_q < count_q;
        issue     = (state_q == StRun) && can_issue && room;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        issued_d    = issued_q;
        pend_d      = issue;
        pend_last_d = issue && (issued_q == (count_q - (AW+1)'(1)));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = base_addr;
                    count_d  = count;
                    issued_d = '0;
                    state_d  = (count == '0) ? StFlush : StRun;
                end
            end
            StRun: begin
                if (issue) begin
                    addr_d   = addr_q + AW'(1);
                    issued_d = issued_q + (AW+1)'(1);
                end
                if (pop && head_last_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;

        unique case (fifo_cnt_q)
            2'd0: begin
                if (push) begin
                    head_data_d = rom_rdata;
                    head_last_d = pend_last_q;
                    fifo_cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_d = rom_rdata;
                    head_last_d = pend_last_q;
                end else if (push) begin
                    tail_data_d = rom_rdata;
                    tail_last_d = pend_last_q;
                    fifo_cnt_d  = 2'd2;
                end else if (pop) begin
                    fifo_cnt_d = 2'd0;
                end
            end
            2'd2: begin
                // Issue throttling guarantees no push into a full FIFO without a pop.
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    if (push) begin
                        tail_data_d = rom_rdata;
                        tail_last_d = pend_last_q;
                    end else begin
                        fifo_cnt_d = 2'd1;
                    end
                end
            end
            default: begin
                fifo_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
        end
    end

`ifdef SCARV_ROM_STREAMER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_acc) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q ^ head_data_q;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StFlush);
    assign rom_cen  = issue;
    assign rom_addr = addr_q;
    assign s_valid  = (fifo_cnt_q != 2'd0);
    assign s_data   = head_data_q;
    // Head last-flag may be stale once the FIFO drains, so qualify it.
    assign s_last   = head_last_q && (fifo_cnt_q != 2'd0);

endmodule

// File: tb/tb_scarv_rom_streamer.sv
// Scoreboard bench for scarv_rom_streamer: directed transfers against a 16-word ROM.
module tb_scarv_rom_streamer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 4;

    logic             g_clk     = 1'b0;
    logic             g_reset   = 1'b1;
    logic             start     = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [AW:0]      count     = '0;
    logic             busy;
    logic             done;
    logic             rom_cen;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_rdata = '0;
    logic             s_valid;
    logic             s_ready   = 1'b1;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] checksum;

    scarv_rom_streamer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_cen   (rom_cen),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .checksum  (checksum)
    );

    always #5 g_clk = ~g_clk;

    // ROM[i] = i + 0x100; garbage when not enabled so stray captures show up.
    always @(posedge g_clk) begin
        rom_rdata <= rom_cen ? (32'h100 + 32'(rom_addr)) : 32'hDEAD_BEEF;
    end

    int          n_vec      = 0;
    int          n_bad      = 0;
    int          n_issued   = 0;
    int          beats_seen = 0;
    bit          stall_v    = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;
    bit          rdy_toggle = 1'b0;
    logic [3:0]  exp_addr[$];
    logic [32:0] exp_beat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] chk(input logic [31:0] v);
`ifdef SCARV_ROM_STREAMER_CHECKSUM_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     32'(busy),    32'h0);
        check({tag, "_done"},     32'(done),    32'h0);
        check({tag, "_rom_cen"},  32'(rom_cen), 32'h0);
        check({tag, "_s_valid"},  32'(s_valid), 32'h0);
        check({tag, "_s_last"},   32'(s_last),  32'h0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
        check({tag, "_s_data"},   s_data,       32'h0);
        check({tag, "_checksum"}, checksum,     32'h0);
    endtask

    // Consumer ready: held high, or toggled every cycle when requested.
    initial begin
        forever begin
            @(posedge g_clk);
            #1;
            s_ready = rdy_toggle ? ~s_ready : 1'b1;
        end
    end

    // Monitor: pops expected ROM addresses and beats as the DUT presents them.
    initial begin
        logic [3:0]  ea;
        logic [32:0] eb;
        forever begin
            @(negedge g_clk);
            if (!g_reset) begin
                if (busy) begin
                    check("fifo_occupancy_le2", 32'((n_issued - beats_seen) <= 2), 32'h1);
                end
                if (rom_cen) begin
                    if (exp_addr.size() == 0) begin
                        check("rom_cen_unexpected", 32'(rom_cen), 32'h0);
                    end else begin
                        ea = exp_addr.pop_front();
                        check("rom_addr", 32'(rom_addr), 32'(ea));
                    end
                    n_issued++;
                end
                if (stall_v) begin
                    check("s_valid_held", 32'(s_valid), 32'h1);
                    check("s_data_stable", s_data, stall_data);
                    check("s_last_stable", 32'(s_last), 32'(stall_last));
                end
                stall_v    = s_valid && !s_ready;
                stall_data = s_data;
                stall_last = s_last;
                if (s_valid && s_ready) begin
                    if (exp_beat.size() == 0) begin
                        check("beat_unexpected", 32'(s_valid), 32'h0);
                    end else begin
                        eb = exp_beat.pop_front();
                        check("s_data", s_data, eb[31:0]);
                        check("s_last", 32'(s_last), 32'(eb[32]));
                    end
                    beats_seen++;
                end
            end
        end
    end

    task automatic push_expect(input logic [3:0] b, input logic [4:0] c);
        logic [3:0] a;
        for (int i = 0; i < int'(c); i++) begin
            a = b + 4'(i);
            exp_addr.push_back(a);
            exp_beat.push_back({(i == int'(c) - 1), 32'h100 + 32'(a)});
        end
    endtask

    // exp_k: negedge index (1 = cycle after the start-sampling edge) where done must pulse.
    task automatic run_xfer(input logic [3:0] b, input logic [4:0] c, input bit tog,
                            input bit restart, input int exp_k, input logic [31:0] exp_chk,
                            input bit chk_lat);
        int k;
        int first_cen;
        int first_val;
        bit got;
        n_issued   = 0;
        beats_seen = 0;
        push_expect(b, c);
        rdy_toggle = tog;
        @(posedge g_clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        count     = c;
        @(posedge g_clk);
        #1;
        start     = 1'b0;
        base_addr = ~b;
        count     = 5'd3;
        k = 0;
        got = 1'b0;
        first_cen = 0;
        first_val = 0;
        while (!got && k < 300) begin
            @(negedge g_clk);
            k++;
            if (restart && k == 3) begin
                start     = 1'b1;
                base_addr = 4'd9;
                count     = 5'd3;
            end
            if (restart && k == 4) begin
                start = 1'b0;
            end
            if (chk_lat && k == 1) begin
                check("busy_after_start", 32'(busy), 32'h1);
            end
            if (rom_cen && first_cen == 0) first_cen = k;
            if (s_valid && first_val == 0) first_val = k;
            if (done) begin
                got = 1'b1;
                check("busy_low_with_done", 32'(busy), 32'h0);
            end
        end
        check("done_seen", 32'(got), 32'h1);
        if (exp_k != 0) check("done_cycle", 32'(k), 32'(exp_k));
        if (chk_lat) begin
            check("first_rom_cen_cycle", 32'(first_cen), 32'h1);
            check("first_s_valid_cycle", 32'(first_val), 32'h3);
        end
        @(negedge g_clk);
        check("done_single_pulse", 32'(done), 32'h0);
        check("beat_count", 32'(beats_seen), 32'(c));
        check("beats_left", 32'(exp_beat.size()), 32'h0);
        check("reads_left", 32'(exp_addr.size()), 32'h0);
        check("checksum", checksum, exp_chk);
        rdy_toggle = 1'b0;
        exp_beat.delete();
        exp_addr.delete();
    endtask

    initial begin
        g_reset = 1'b1;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check_zero("reset");
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;

        run_xfer(4'd3, 5'd4, 1'b0, 1'b0, 7, chk(32'h004), 1'b1);
        run_xfer(4'd14, 5'd4, 1'b0, 1'b0, 7, chk(32'h000), 1'b0);
        run_xfer(4'd2, 5'd5, 1'b0, 1'b1, 8, chk(32'h106), 1'b0);
        run_xfer(4'd9, 5'd0, 1'b0, 1'b0, 1, chk(32'h000), 1'b0);
        run_xfer(4'd7, 5'd16, 1'b1, 1'b0, 0, chk(32'h000), 1'b0);

        // Reset in the middle of a count=8 transfer.
        n_issued   = 0;
        beats_seen = 0;
        push_expect(4'd5, 5'd8);
        @(posedge g_clk);
        #1;
        start     = 1'b1;
        base_addr = 4'd5;
        count     = 5'd8;
        @(posedge g_clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && beats_seen < 2; i++) @(negedge g_clk);
        check("beats_before_reset", 32'(beats_seen), 32'h2);
        @(posedge g_clk);
        #1;
        g_reset = 1'b1;
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        exp_addr.delete();
        exp_beat.delete();
        stall_v    = 1'b0;
        n_issued   = 0;
        beats_seen = 0;
        @(negedge g_clk);
        check_zero("mid_reset");
        run_xfer(4'd0, 5'd1, 1'b0, 1'b0, 4, chk(32'h100), 1'b0);

        repeat (3) @(posedge g_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
